instruction_decoder: RTL and testbench
======================================

// Module: instruction_decoder
// PURPOSE
//  Fetch-side partner of the program sequencer. Captures the program-memory word for pm_addr
//  and decodes it into the sequencer's jump controls (jmp, jmp_nz, jmp_addr, dont_jmp) and the
//  datapath load/select/ALU controls. Holds the instruction register, pipeline valid bit and zero flag.
//  Sits between program memory output and the sequencer/datapath of the MPU.
// PARAMETERS
//  IW    8   instruction width (opcode map below is defined for 8 only)
//  DW    4   immediate/jump-address width
//  NREG  8   number of datapath destinations (one-hot ld_en width)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset_n    in   1   asynchronous active-low reset
//  pm_data    in   8   program-memory word for the address issued on the previous cycle
//  alu_zero   in   1   ALU result==0, valid in the cycle alu_en is high
//  ir         out  8   registered instruction word
//  ir_valid   out  1   ir holds an executable (non-squashed) instruction
//  jmp        out  1   unconditional jump to sequencer
//  jmp_nz     out  1   conditional jump (taken when zero flag clear) to sequencer
//  jmp_addr   out  4   jump target to sequencer
//  dont_jmp   out  1   zero-flag state to sequencer; 1 = suppress jmp_nz
//  ld_en      out  8   one-hot destination load enable
//  src_sel    out  3   datapath source mux select
//  imm        out  4   immediate data
//  imm_sel    out  1   1 = destination loads imm, 0 = loads src_sel source
//  alu_func   out  3   ALU operation
//  alu_en     out  1   ALU operation issued this cycle
// BEHAVIOUR
//  Opcode map (ir[7:0]):
//   0ddd_iiii  LOAD imm: ld_en[ddd]=1, imm=iiii, imm_sel=1
//   10dd_dsss  MOVE: ld_en[ddd]=1, src_sel=sss, imm_sel=0; ddd==sss is a NOP (no ld_en)
//   110f_ffxx  ALU: alu_en=1, alu_func=fff (bits 4:2); bits 1:0 ignored
//   1110_aaaa  JMP: jmp=1, jmp_addr=aaaa
//   1111_aaaa  JNZ: jmp_nz=1, jmp_addr=aaaa
//  Pipeline: every rising clk, ir <= pm_data; decode is combinational from ir, gated by ir_valid.
//  Taken-jump flush: if jmp=1, or jmp_nz=1 with dont_jmp=0, the word fetched in that cycle is
//   squashed: ir_valid <= 0 next cycle. Not-taken JNZ does not flush.
//   Squash does not chain: a squashed JMP/JNZ in ir never causes a flush.
//  ir_valid <= 1 every cycle except the cycle following a taken jump.
//  ir_valid=0: all controls (jmp, jmp_nz, ld_en, alu_en, imm_sel) are 0. ir, imm, src_sel,
//   alu_func and jmp_addr still reflect ir.
//  Zero flag z: z <= alu_zero when alu_en&ir_valid; otherwise holds. LOAD/MOVE/JMP/JNZ never
//   change z. dont_jmp = z (registered value, no same-cycle bypass).
//   An ALU op followed immediately by JNZ therefore tests the updated flag.
//  Reset (reset_n=0, async): ir=8'h00, ir_valid=0, z=1, so dont_jmp=1; all controls 0.
//   jmp/jmp_nz are low while in reset. First valid instruction is the word at pm_addr 0, in ir
//   one cycle after reset release. Reset mid-jump discards any pending flush.
//  Latency: pm_data -> controls = 1 clk. Taken jump costs 1 bubble cycle.
//  Widths: jmp_addr is 4 bits. Jump targets are 8'h00-8'h0F when zero-extended by the sequencer.
// TESTING
//  1 Reset: hold reset_n=0 with pm_data=8'hE5 -> ir=00, ir_valid=0, jmp=0, dont_jmp=1; release ->
//    ir_valid=1 next edge.
//  2 LOAD/MOVE: 8'h3A -> ld_en=8'b0000_1000, imm=A, imm_sel=1; 8'h91 -> ld_en[2]=1, src_sel=1;
//    8'h92 -> ld_en=0 (NOP).
//  3 JMP flush: 8'hE7 then 8'h3A -> jmp=1, jmp_addr=7; next cycle ir_valid=0, ld_en=0;
//    following word executes normally.
//  4 JNZ: ALU op with alu_zero=0 then 8'hF3 -> jmp_nz=1, dont_jmp=0, flush.
//    Repeat with alu_zero=1 -> dont_jmp=1, no flush.
//  5 Squash chain: 8'hE2 followed by 8'hE9 -> second jump squashed (jmp=0 that cycle).
//    Only target 2 taken.
//  6 Async reset mid-flush: assert reset_n between clocks after a taken jump ->
//    outputs clear immediately, no leftover bubble.

Source files
------------

// File: rtl/instruction_decoder.sv
//------------------------------------------------------------------------------
// instruction_decoder: instruction register, squash bit, zero flag and decode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_decoder #(
  parameter int IW   = 8,
  parameter int DW   = 4,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IW-1:0]   pm_data,
  input  logic            alu_zero,
  output logic [IW-1:0]   ir,
  output logic            ir_valid,
  output logic            jmp,
  output logic            jmp_nz,
  output logic [DW-1:0]   jmp_addr,
  output logic            dont_jmp,
  output logic [NREG-1:0] ld_en,
  output logic [2:0]      src_sel,
  output logic [DW-1:0]   imm,
  output logic            imm_sel,
  output logic [2:0]      alu_func,
  output logic            alu_en
);

  logic            z;
  logic            taken;
  logic [NREG-1:0] dec_ld;
  logic            dec_imm_sel;
  logic            dec_alu;
  logic            dec_jmp;
  logic            dec_jnz;

  always_comb begin
    dec_ld      = '0;
    dec_imm_sel = 1'b0;
    dec_alu     = 1'b0;
    dec_jmp     = 1'b0;
    dec_jnz     = 1'b0;
    casez (ir)
      8'b0???_????: begin
        dec_ld[ir[6:4]] = 1'b1;
        dec_imm_sel     = 1'b1;
      end
      8'b10??_????: begin
        // Moving a register onto itself is the NOP encoding
        if (ir[5:3] != ir[2:0]) dec_ld[ir[5:3]] = 1'b1;
      end
      8'b110?_????: dec_alu = 1'b1;
      8'b1110_????: dec_jmp = 1'b1;
      8'b1111_????: dec_jnz = 1'b1;
      default: ;
    endcase
  end

  assign ld_en    = ir_valid ? dec_ld : '0;
  assign imm_sel  = ir_valid & dec_imm_sel;
  assign alu_en   = ir_valid & dec_alu;
  assign jmp      = ir_valid & dec_jmp;
  assign jmp_nz   = ir_valid & dec_jnz;
  assign jmp_addr = ir[DW-1:0];
  assign imm      = ir[DW-1:0];
  assign src_sel  = ir[2:0];
  assign alu_func = ir[4:2];
  assign dont_jmp = z;

  // Squashed jumps are already gated off above, so flushes cannot chain
  assign taken = jmp | (jmp_nz & ~z);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      z        <= 1'b1;
    end else begin
      ir       <= pm_data;
      ir_valid <= ~taken;
      if (alu_en) z <= alu_zero;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_decoder.sv
// tb_instruction_decoder: directed vectors, expectations queued and checked by a monitor
`default_nettype none

module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic [7:0] ir;
  logic       ir_valid, jmp, jmp_nz, dont_jmp, imm_sel, alu_en;
  logic [3:0] jmp_addr, imm;
  logic [7:0] ld_en;
  logic [2:0] src_sel, alu_func;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [35:0] v;
  } exp_t;

  exp_t sb[$];

  instruction_decoder #(.IW(8), .DW(4), .NREG(8)) dut (
    .clk(clk), .reset_n(reset_n), .pm_data(pm_data), .alu_zero(alu_zero),
    .ir(ir), .ir_valid(ir_valid), .jmp(jmp), .jmp_nz(jmp_nz),
    .jmp_addr(jmp_addr), .dont_jmp(dont_jmp), .ld_en(ld_en),
    .src_sel(src_sel), .imm(imm), .imm_sel(imm_sel),
    .alu_func(alu_func), .alu_en(alu_en)
  );

  always #5 clk = ~clk;

  // Expected ir plus hand-computed controls; passive fields are fixed slices of ir
  task automatic push(input int id, input logic [7:0] e_ir, input logic v,
                      input logic j, input logic jn, input logic dj,
                      input logic [7:0] ld, input logic isel, input logic ae);
    exp_t e;
    e.id = id;
    e.v  = {e_ir, v, j, jn, e_ir[3:0], dj, ld, e_ir[2:0], e_ir[3:0], isel, e_ir[4:2], ae};
    sb.push_back(e);
  endtask

  task automatic drive(input logic [7:0] pm, input logic az, input logic rn);
    @(negedge clk);
    pm_data  = pm;
    alu_zero = az;
    reset_n  = rn;
  endtask

  // Monitor: every clock edge and every async reset assertion presents outputs
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        logic [35:0] act;
        e   = sb.pop_front();
        act = {ir, ir_valid, jmp, jmp_nz, jmp_addr, dont_jmp, ld_en,
               src_sel, imm, imm_sel, alu_func, alu_en};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL step%0d: got ir=%h v=%b jmp=%b jnz=%b ja=%h dj=%b ld=%b src=%h imm=%h isel=%b fn=%h ae=%b, expected packed %h got %h",
                   e.id, ir, ir_valid, jmp, jmp_nz, jmp_addr, dont_jmp, ld_en,
                   src_sel, imm, imm_sel, alu_func, alu_en, e.v, act);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    pm_data  = 8'hE5;
    alu_zero = 1'b0;

    // Reset held with a jump word on the bus
    drive(8'hE5, 0, 0); push( 1, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    drive(8'hE5, 0, 0); push( 2, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    // Release: first word valid after one edge; LOAD / MOVE / NOP
    drive(8'h3A, 0, 1); push( 3, 8'h3A, 1, 0, 0, 1, 8'h08, 1, 0);
    drive(8'h91, 0, 1); push( 4, 8'h91, 1, 0, 0, 1, 8'h04, 0, 0);
    drive(8'h92, 0, 1); push( 5, 8'h92, 1, 0, 0, 1, 8'h00, 0, 0);
    // JMP flushes the following word
    drive(8'hE7, 0, 1); push( 6, 8'hE7, 1, 1, 0, 1, 8'h00, 0, 0);
    drive(8'h3A, 0, 1); push( 7, 8'h3A, 0, 0, 0, 1, 8'h00, 0, 0);
    drive(8'h25, 0, 1); push( 8, 8'h25, 1, 0, 0, 1, 8'h04, 1, 0);
    // ALU clears z, JNZ taken and flushes
    drive(8'hC4, 0, 1); push( 9, 8'hC4, 1, 0, 0, 1, 8'h00, 0, 1);
    drive(8'hF3, 0, 1); push(10, 8'hF3, 1, 0, 1, 0, 8'h00, 0, 0);
    drive(8'h3A, 0, 1); push(11, 8'h3A, 0, 0, 0, 0, 8'h00, 0, 0);
    // ALU sets z, JNZ not taken, no flush
    drive(8'hD8, 0, 1); push(12, 8'hD8, 1, 0, 0, 0, 8'h00, 0, 1);
    drive(8'hF5, 1, 1); push(13, 8'hF5, 1, 0, 1, 1, 8'h00, 0, 0);
    drive(8'h1C, 0, 1); push(14, 8'h1C, 1, 0, 0, 1, 8'h02, 1, 0);
    // Squash does not chain
    drive(8'hE2, 0, 1); push(15, 8'hE2, 1, 1, 0, 1, 8'h00, 0, 0);
    drive(8'hE9, 0, 1); push(16, 8'hE9, 0, 0, 0, 1, 8'h00, 0, 0);
    drive(8'h45, 0, 1); push(17, 8'h45, 1, 0, 0, 1, 8'h10, 1, 0);
    // Squashed ALU op must not touch z
    drive(8'hE0, 0, 1); push(18, 8'hE0, 1, 1, 0, 1, 8'h00, 0, 0);
    drive(8'hC0, 0, 1); push(19, 8'hC0, 0, 0, 0, 1, 8'h00, 0, 0);
    drive(8'hF6, 0, 1); push(20, 8'hF6, 1, 0, 1, 1, 8'h00, 0, 0);
    drive(8'h31, 0, 1); push(21, 8'h31, 1, 0, 0, 1, 8'h08, 1, 0);
    // Async reset while a taken jump is pending
    drive(8'hEA, 0, 1); push(22, 8'hEA, 1, 1, 0, 1, 8'h00, 0, 0);
    @(negedge clk);
    pm_data = 8'h5B;
    push(23, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    push(24, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    #2 reset_n = 1'b0;
    drive(8'h5B, 0, 1); push(25, 8'h5B, 1, 0, 0, 1, 8'h20, 1, 0);
    drive(8'hA8, 0, 1); push(26, 8'hA8, 1, 0, 0, 1, 8'h20, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
